// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared definitions for the frequency meter slice.
//   state_t          - FSM state encoding (IDLE/ARM/MEASURE/DONE)
//   CNT_W_DEF        - default counter/result width
//   SYNC_STAGES_DEF  - default synchroniser depth
package freq_meter_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if: request/result handshake of the frequency meter.
//   START     - single-cycle measurement request (master -> slave)
//   READY     - consumer accepts the result      (master -> slave)
//   BUSY      - measurement in progress           (slave -> master)
//   VALID     - result available                  (slave -> master)
//   TIMEOUT   - result is a timeout                (slave -> master)
//   PERIOD    - rise-to-rise cycles                (slave -> master)
//   HIGH_TIME - rise-to-fall cycles                (slave -> master)
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             START;
  logic             READY;
  logic             BUSY;
  logic             VALID;
  logic             TIMEOUT;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_TIME;

  modport master (
    output START, READY,
    input  BUSY, VALID, TIMEOUT, PERIOD, HIGH_TIME
  );

  modport slave (
    input  START, READY,
    output BUSY, VALID, TIMEOUT, PERIOD, HIGH_TIME
  );

endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det: synchronises an asynchronous input and flags its edges.
//   CLK      - system clock
//   RST_N    - asynchronous active-low reset (all flops clear to 0)
//   async_in - asynchronous input
//   rise     - synchronised level went 0 -> 1 this cycle
//   fall     - synchronised level went 1 -> 0 this cycle
// Both edges share the same latency, so edge-to-edge intervals are exact
// for inputs that are already synchronous to CLK.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   p;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      p      <= s;
    end
  end

  assign rise = s & ~p;
  assign fall = ~s & p;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of a slow asynchronous square
// wave in CLK cycles, one measurement per START, result handed off with
// VALID/READY.
//   CLK    - system clock
//   RST_N  - asynchronous active-low reset
//   SIG_IN - signal under measurement (asynchronous)
//   bus    - freq_meter_if slave: START/READY in, BUSY/VALID/TIMEOUT/
//            PERIOD/HIGH_TIME out
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         SIG_IN,
  freq_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fall_seen;
  logic             busy_q;
  logic             valid_q;
  logic             timeout_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             rise;
  logic             fall;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .async_in (SIG_IN),
    .rise     (rise),
    .fall     (fall)
  );

  // Counter leaves ARM/MEASURE on reaching all-ones, so it saturates
  // rather than wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      fall_seen   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.START) begin
            state  <= ARM;
            busy_q <= 1'b1;
          end
        end

        ARM: begin
          if (rise) begin
            state     <= MEASURE;
            cnt       <= CNT_ONE;
            fall_seen <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b1;
            timeout_q   <= 1'b1;
            period_q    <= '0;
            high_time_q <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        MEASURE: begin
          if (fall && !fall_seen) begin
            high_time_q <= cnt;
            fall_seen   <= 1'b1;
          end
          if (rise) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            period_q  <= cnt;
          end else if (cnt == CNT_MAX) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            period_q  <= CNT_MAX;
            if (!fall_seen) high_time_q <= CNT_MAX;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DONE: begin
          if (bus.READY) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BUSY      = busy_q;
  assign bus.VALID     = valid_q;
  assign bus.TIMEOUT   = timeout_q;
  assign bus.PERIOD    = period_q;
  assign bus.HIGH_TIME = high_time_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: self-checking bench for freq_meter. Two instances
// (CNT_W=16 and CNT_W=8) share clock, reset and SIG_IN. Expected results
// come from the waveform description: period = high + low, high time =
// high, timeouts give fixed constants derived from the counter width.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int SYNC = 2;
  localparam int O_BUSY = 0, O_VALID = 1, O_TO = 2, O_PER = 3, O_HI = 4;

  logic CLK;
  logic RST_N;
  logic SIG;

  freq_meter_if #(.CNT_W(16)) b16 ();
  freq_meter_if #(.CNT_W(8))  b8 ();

  freq_meter #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut_16 (
    .CLK(CLK), .RST_N(RST_N), .SIG_IN(SIG), .bus(b16));
  freq_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut_8 (
    .CLK(CLK), .RST_N(RST_N), .SIG_IN(SIG), .bus(b8));

  int n_tests = 0;
  int n_fail  = 0;

  // waveform generator controls
  int   gen_hi = 4, gen_lo = 4, gen_ep = 0;
  bit   gen_run = 1'b0;
  logic gen_const = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SIG changes 1 time unit after posedge, so it is CLK-synchronous
  initial begin
    int last_ep;
    int gcnt;
    last_ep = 0;
    gcnt    = 0;
    SIG     = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (!gen_run) begin
        SIG     = gen_const;
        last_ep = gen_ep;
      end else if (gen_ep != last_ep) begin
        last_ep = gen_ep;
        SIG     = 1'b0;
        gcnt    = 0;
      end else begin
        gcnt++;
        if (gcnt >= (SIG ? gen_hi : gen_lo)) begin
          SIG  = ~SIG;
          gcnt = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] obs(input bit s8, input int f);
    logic [31:0] r;
    r = '0;
    case (f)
      O_BUSY:  r = s8 ? 32'(b8.BUSY)      : 32'(b16.BUSY);
      O_VALID: r = s8 ? 32'(b8.VALID)     : 32'(b16.VALID);
      O_TO:    r = s8 ? 32'(b8.TIMEOUT)   : 32'(b16.TIMEOUT);
      O_PER:   r = s8 ? 32'(b8.PERIOD)    : 32'(b16.PERIOD);
      default: r = s8 ? 32'(b8.HIGH_TIME) : 32'(b16.HIGH_TIME);
    endcase
    return r;
  endfunction

  task automatic set_start(input bit s8, input logic v);
    if (s8) b8.START = v; else b16.START = v;
  endtask

  task automatic set_ready(input bit s8, input logic v);
    if (s8) b8.READY = v; else b16.READY = v;
  endtask

  task automatic set_wave(input int hi, input int lo);
    gen_hi  = hi;
    gen_lo  = lo;
    gen_run = 1'b1;
    gen_ep++;
    repeat ((hi + lo) * 2 + 8) tick();
  endtask

  task automatic set_const(input logic lvl);
    gen_run   = 1'b0;
    gen_const = lvl;
  endtask

  task automatic wait_valid(input bit s8, input string tag, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs(s8, O_VALID) == 32'd1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input bit s8, input string tag, input int ep, input int eh, input int et);
    chk({tag, "_period"}, obs(s8, O_PER), 32'(ep));
    chk({tag, "_high"},   obs(s8, O_HI),  32'(eh));
    chk({tag, "_timeout"}, obs(s8, O_TO), 32'(et));
  endtask

  task automatic accept(input bit s8, input string tag);
    set_ready(s8, 1'b1);
    tick();
    set_ready(s8, 1'b0);
    chk({tag, "_valid_drop"}, obs(s8, O_VALID), 32'd0);
    chk({tag, "_busy_after"}, obs(s8, O_BUSY), 32'd0);
  endtask

  // start, wait for result, check, hold READY low 'hold' cycles, accept
  task automatic measure(input bit s8, input string tag, input int ep, input int eh,
                         input int et, input int hold);
    bit ok;
    set_start(s8, 1'b1);
    tick();
    set_start(s8, 1'b0);
    chk({tag, "_busy"}, obs(s8, O_BUSY), 32'd1);
    wait_valid(s8, tag, 2000, ok);
    if (ok) begin
      chk({tag, "_busy_done"}, obs(s8, O_BUSY), 32'd0);
      check_result(s8, tag, ep, eh, et);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, "_hold_valid"}, obs(s8, O_VALID), 32'd1);
        check_result(s8, {tag, "_hold"}, ep, eh, et);
      end
    end
    accept(s8, tag);
  endtask

  initial begin
    bit ok;
    int hi, lo, hold;

    RST_N     = 1'b0;
    b16.START = 1'b0;
    b16.READY = 1'b0;
    b8.START  = 1'b0;
    b8.READY  = 1'b0;
    repeat (3) tick();
    chk("rst_busy",    obs(0, O_BUSY),  32'd0);
    chk("rst_valid",   obs(0, O_VALID), 32'd0);
    chk("rst_timeout", obs(0, O_TO),    32'd0);
    chk("rst_period",  obs(0, O_PER),   32'd0);
    chk("rst_high",    obs(0, O_HI),    32'd0);
    chk("rst8_valid",  obs(1, O_VALID), 32'd0);
    RST_N = 1'b1;
    repeat (SYNC + 2) tick();

    // divide-by-8
    set_wave(4, 4);
    measure(0, "div8", 8, 4, 0, 0);

    // duty 3/7 with READY held low for 10 cycles
    set_wave(3, 7);
    measure(0, "duty", 10, 3, 0, 10);

    // stuck low, 8-bit counter: timeout in ARM
    set_const(1'b0);
    repeat (SYNC + 4) tick();
    measure(1, "stuck_low", 0, 0, 1, 0);

    // one rise then stuck high: timeout in MEASURE, no fall captured
    set_const(1'b0);
    repeat (SYNC + 4) tick();
    set_start(1, 1'b1);
    tick();
    set_start(1, 1'b0);
    repeat (3) tick();
    set_const(1'b1);
    wait_valid(1, "stuck_high", 1000, ok);
    if (ok) check_result(1, "stuck_high", (1 << 8) - 1, (1 << 8) - 1, 1);
    accept(1, "stuck_high");

    // reset 5 cycles into MEASURE
    set_wave(20, 20);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (dut_16.state == MEASURE) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("rstmid_reach_measure", 32'd0, 32'd1);
    repeat (5) tick();
    RST_N = 1'b0;
    #1;
    chk("rstmid_busy",    obs(0, O_BUSY),  32'd0);
    chk("rstmid_valid",   obs(0, O_VALID), 32'd0);
    chk("rstmid_timeout", obs(0, O_TO),    32'd0);
    chk("rstmid_period",  obs(0, O_PER),   32'd0);
    chk("rstmid_high",    obs(0, O_HI),    32'd0);
    chk("rstmid_state",   32'(dut_16.state), 32'(IDLE));
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (SYNC + 2) tick();
    set_wave(3, 3);
    measure(0, "after_rst", 6, 3, 0, 0);

    // START held through ARM, MEASURE and DONE, and with the READY acceptance
    set_wave(5, 5);
    set_start(0, 1'b1);
    tick();
    chk("ign_busy", obs(0, O_BUSY), 32'd1);
    wait_valid(0, "ign", 2000, ok);
    if (ok) check_result(0, "ign", 10, 5, 0);
    repeat (3) tick();
    chk("ign_done_valid", obs(0, O_VALID), 32'd1);
    set_ready(0, 1'b1);
    tick();
    set_ready(0, 1'b0);
    set_start(0, 1'b0);
    chk("ign_valid_drop", obs(0, O_VALID), 32'd0);
    chk("ign_busy_after", obs(0, O_BUSY),  32'd0);
    repeat (5) tick();
    chk("ign_busy_later", obs(0, O_BUSY),  32'd0);
    chk("ign_valid_later", obs(0, O_VALID), 32'd0);

    // randomised duty cycles
    for (int n = 0; n < 10; n++) begin
      hi   = int'($urandom_range(1, 30));
      lo   = int'($urandom_range(1, 30));
      hold = int'($urandom_range(0, 3));
      set_wave(hi, lo);
      measure(0, $sformatf("rnd%0d_h%0d_l%0d", n, hi, lo), hi + lo, hi, 0, hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
